// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - load/store request and response bundle for data_mem
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface data_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        fault;
  logic        init_busy;

  modport master (
    output mem_read, mem_write, func3, addr, wr_data,
    input  rd_data, rd_valid, fault, init_busy
  );

  modport slave (
    input  mem_read, mem_write, func3, addr, wr_data,
    output rd_data, rd_valid, fault, init_busy
  );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory with load/store unit and power-on clear
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_mem #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH      = `DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_DEPTH_WORDS - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [AW-1:0]         counter;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic           req_load;
  logic           req_store;
  logic           req_both;
  logic           load_ok;
  logic           store_ok;
  logic [3:0]     st_be;
  logic [31:0]    st_data;
  logic [31:0]    rd_word;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_ext;
  logic           mem_we;
  logic [AW-1:0]  mem_widx;
  logic [3:0]     mem_be;
  logic [31:0]    mem_wdata;
  logic           unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
  assign idx         = bus.addr[AW+1:2];
  assign lane        = bus.addr[1:0];
  assign unused_addr = ^bus.addr[31:AW+2];

  assign req_load  = bus.mem_read & ~bus.mem_write;
  assign req_store = bus.mem_write & ~bus.mem_read;
  assign req_both  = bus.mem_read & bus.mem_write;

  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    st_be    = 4'b0000;
    st_data  = bus.wr_data;
    case (bus.func3)
      3'b000: begin
        load_ok  = 1'b1;
        store_ok = 1'b1;
        st_be    = 4'b0001 << lane;
        st_data  = {4{bus.wr_data[7:0]}};
      end
      3'b001: begin
        load_ok  = ~bus.addr[0];
        store_ok = ~bus.addr[0];
        st_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{bus.wr_data[15:0]}};
      end
      3'b010: begin
        load_ok  = (lane == 2'b00);
        store_ok = (lane == 2'b00);
        st_be    = 4'b1111;
      end
      3'b100:  load_ok = 1'b1;
      3'b101:  load_ok = ~bus.addr[0];
      default: ;
    endcase
  end

  always_comb begin
    rd_word = mem[idx];
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.func3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // The clear sequence and accepted stores share one write port; rst suppresses both.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx;
    mem_be    = st_be;
    mem_wdata = st_data;
    if (state == INIT) begin
      mem_we    = ~rst;
      mem_widx  = counter;
      mem_be    = 4'b1111;
      mem_wdata = 32'h00000000;
    end else begin
      mem_we = ~rst & req_store & store_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      counter       <= '0;
      bus.rd_data   <= 32'h00000000;
      bus.rd_valid  <= 1'b0;
      bus.fault     <= 1'b0;
      bus.init_busy <= 1'b1;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.fault    <= 1'b0;
      case (state)
        INIT: begin
          if (counter == LAST_WORD) begin
            state         <= READY;
            bus.init_busy <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        READY: begin
          if (req_load) begin
            if (load_ok) begin
              bus.rd_data  <= ld_ext;
              bus.rd_valid <= 1'b1;
            end else begin
              bus.fault <= 1'b1;
            end
          end else if (req_store) begin
            bus.fault <= ~store_ok;
          end else if (req_both) begin
            bus.fault <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem (16-word and 1024-word instances)
module tb_data_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_if s_if ();
  data_mem_if b_if ();

  data_mem #(.MEM_DEPTH_WORDS(16))   dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
  data_mem #(.MEM_DEPTH_WORDS(1024)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // Both instances receive identical stimulus; every address used maps to the same word in each.
  task automatic drive(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    s_if.mem_read = r; s_if.mem_write = w; s_if.func3 = f; s_if.addr = a; s_if.wr_data = d;
    b_if.mem_read = r; b_if.mem_write = w; b_if.func3 = f; b_if.addr = a; b_if.wr_data = d;
  endtask

  task automatic req(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(r, w, f, a, d);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic count_clear(output int ns, output int nb, output bit nz);
    ns = 0; nb = 0; nz = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1;
      if (s_if.rd_data != 32'h0) nz = 1'b1;
      if (ns == 0 && !s_if.init_busy) ns = c;
      if (!b_if.init_busy) begin
        nb = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int ns, nb;
    bit nz;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({s_if.init_busy, s_if.rd_valid, s_if.fault, b_if.init_busy, b_if.rd_valid, b_if.fault} !== 6'b100100
        || s_if.rd_data !== 32'h0 || b_if.rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: s busy/vld/flt/rd=%b%b%b/%h b=%b%b%b/%h required 100/0",
               s_if.init_busy, s_if.rd_valid, s_if.fault, s_if.rd_data, b_if.init_busy, b_if.rd_valid, b_if.fault, b_if.rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h0000_003C, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (s_if.fault !== 1'b0 || s_if.rd_valid !== 1'b0 || s_if.init_busy !== 1'b1 || b_if.fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_drop_%0d: fault=%b vld=%b busy=%b required 0 0 1", i, s_if.fault, s_if.rd_valid, s_if.init_busy);
      end
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    count_clear(ns, nb, nz);
    tests_run++;
    if (ns + 4 !== 16) begin
      tests_failed++;
      $display("FAIL clear_len_16: busy cycles=%0d required 16", ns + 4);
    end
    tests_run++;
    if (nb + 4 !== 1024) begin
      tests_failed++;
      $display("FAIL clear_len_1024: busy cycles=%0d required 1024", nb + 4);
    end
    tests_run++;
    if (nz !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_rd_data: rd_data nonzero=%b required 0", nz);
    end
    req(1'b1, 1'b0, 3'b010, 32'h0000_003C, 32'h0);
    tests_run++;
    if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== 32'h0 || b_if.rd_valid !== 1'b1 || b_if.rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL lw_3c_cleared: s=%b/%h b=%b/%h required 1/00000000", s_if.rd_valid, s_if.rd_data, b_if.rd_valid, b_if.rd_data);
    end
  endtask

  task automatic test_word_subword;
    logic [2:0]  f3  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad  [5] = '{32'h1000, 32'h1000, 32'h1003, 32'h1002, 32'h1000};
    logic [31:0] exp [5] = '{32'hDEADBEEF, 32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    req(1'b0, 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF);
    tests_run++;
    if (s_if.rd_valid !== 1'b0 || s_if.fault !== 1'b0 || b_if.fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_ack: vld=%b fault=%b required 0 0", s_if.rd_valid, s_if.fault);
    end
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 1'b0, f3[i], ad[i], 32'h0);
      tests_run++;
      if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== exp[i] || b_if.rd_valid !== 1'b1 || b_if.rd_data !== exp[i]) begin
        tests_failed++;
        $display("FAIL load_f3_%b_%h: s=%b/%h b=%b/%h required 1/%h", f3[i], ad[i],
                 s_if.rd_valid, s_if.rd_data, b_if.rd_valid, b_if.rd_data, exp[i]);
      end
    end
  endtask

  task automatic test_lane_preserve;
    req(1'b0, 1'b1, 3'b000, 32'h1001, 32'hAABBCC12);
    req(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
    tests_run++;
    if (s_if.rd_data !== 32'hDEAD12EF || b_if.rd_data !== 32'hDEAD12EF) begin
      tests_failed++;
      $display("FAIL sb_lane: s=%h b=%h required DEAD12EF", s_if.rd_data, b_if.rd_data);
    end
  endtask

  task automatic test_faults;
    bit          r   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          w   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3  [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] ad  [4] = '{32'h1002, 32'h1001, 32'h1000, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      req(r[i], w[i], f3[i], ad[i], 32'h5555_5555);
      tests_run++;
      if (s_if.fault !== 1'b1 || s_if.rd_valid !== 1'b0 || s_if.rd_data !== 32'hDEAD12EF
          || b_if.fault !== 1'b1 || b_if.rd_valid !== 1'b0 || b_if.rd_data !== 32'hDEAD12EF) begin
        tests_failed++;
        $display("FAIL fault_case_%0d: s flt/vld/rd=%b/%b/%h b=%b/%b/%h required 1/0/DEAD12EF", i,
                 s_if.fault, s_if.rd_valid, s_if.rd_data, b_if.fault, b_if.rd_valid, b_if.rd_data);
      end
      req(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
      tests_run++;
      if (s_if.fault !== 1'b0 || s_if.rd_valid !== 1'b1 || s_if.rd_data !== 32'hDEAD12EF || b_if.rd_data !== 32'hDEAD12EF) begin
        tests_failed++;
        $display("FAIL fault_nowrite_%0d: flt/vld=%b/%b s=%h b=%h required 0/1 DEAD12EF", i,
                 s_if.fault, s_if.rd_valid, s_if.rd_data, b_if.rd_data);
      end
    end
  endtask

  task automatic test_wrap;
    req(1'b0, 1'b1, 3'b010, 32'h1000, 32'h11111111);
    req(1'b1, 1'b0, 3'b010, 32'h0000, 32'h0);
    tests_run++;
    if (b_if.rd_data !== 32'h11111111 || s_if.rd_data !== 32'h11111111) begin
      tests_failed++;
      $display("FAIL wrap: b=%h s=%h required 11111111", b_if.rd_data, s_if.rd_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] val [3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
    for (int i = 0; i < 3; i++) req(1'b0, 1'b1, 3'b010, 32'(4 * (i + 1)), val[i]);
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b0, 3'b010, 32'(4 * (i + 1)), 32'h0);
      tests_run++;
      if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== val[i] || b_if.rd_valid !== 1'b1 || b_if.rd_data !== val[i]) begin
        tests_failed++;
        $display("FAIL b2b_load_%0d: s=%b/%h b=%b/%h required 1/%h", i,
                 s_if.rd_valid, s_if.rd_data, b_if.rd_valid, b_if.rd_data, val[i]);
      end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (s_if.rd_valid !== 1'b0 || b_if.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: rd_valid s=%b b=%b required 0", s_if.rd_valid, b_if.rd_valid);
    end
  endtask

  task automatic test_reset_mid_load;
    int ns, nb;
    bit nz;
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tests_run++;
    if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 32'h0 || s_if.init_busy !== 1'b1 || b_if.rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_load: vld=%b rd=%h busy=%b b_rd=%h required 0 00000000 1 00000000",
               s_if.rd_valid, s_if.rd_data, s_if.init_busy, b_if.rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    count_clear(ns, nb, nz);
    tests_run++;
    if (ns !== 16 || nb !== 1024) begin
      tests_failed++;
      $display("FAIL rst_mid_load_clear: s=%0d b=%0d required 16 1024", ns, nb);
    end
  endtask

  task automatic test_reset_mid_clear;
    int ns, nb;
    bit nz;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_clear(ns, nb, nz);
    tests_run++;
    if (ns !== 16) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: busy cycles after release=%0d required 16", ns);
    end
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    tests_run++;
    if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== 32'h0 || b_if.rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL recleared: s=%b/%h b=%h required 1/00000000", s_if.rd_valid, s_if.rd_data, b_if.rd_data);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    test_reset;
    test_word_subword;
    test_lane_preserve;
    test_faults;
    test_wrap;
    test_back_to_back;
    test_reset_mid_load;
    test_reset_mid_clear;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
